// File: rtl/usb_token_crc5_checker.sv
`default_nettype none
// ============================================================================
// Module   : usb_token_crc5_checker
// Purpose  : Receive-side serial checker for USB token fields. Accepts the
//            16-bit token payload (7-bit address, 4-bit endpoint, 5-bit CRC5)
//            one bit per qualified clock, checks the CRC5 residual and
//            presents the deserialized address/endpoint with a pass/fail flag
//            and a one-cycle completion pulse.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active low
//            start      - one-cycle pulse, arms a new token field
//            data_in    - serial payload bit (LSB of addr first)
//            data_valid - qualifies data_in
//            busy       - high while shifting or checking
//            done       - one-cycle pulse, results valid from this cycle on
//            crc_ok     - 1 = residual matched on the last completed token
//            addr[6:0]  - received device address
//            endp[3:0]  - received endpoint
//            err_cnt    - saturating CRC error count
// Config   : define CRC5_ERR_COUNT_EN to build the error counter; otherwise
//            err_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module usb_token_crc5_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       data_in,
    input  logic       data_valid,
    output logic       busy,
    output logic       done,
    output logic       crc_ok,
    output logic [6:0] addr,
    output logic [3:0] endp,
    output logic [7:0] err_cnt
);

    localparam logic [4:0] c_LFSR_SEED = 5'b11111;
    localparam logic [4:0] c_LFSR_POLY = 5'b00101;
    // Remainder left in the register after data plus a correct CRC field.
    localparam logic [4:0] c_RESIDUAL  = 5'b01100;
    localparam logic [3:0] c_LAST_BIT  = 4'd15;
    localparam logic [3:0] c_CAP_BITS  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [4:0]  lfsr_q,   lfsr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [10:0] cap_q,    cap_d;
    logic        done_q,   done_d;
    logic        crc_ok_q, crc_ok_d;
    logic [6:0]  addr_q,   addr_d;
    logic [3:0]  endp_q,   endp_d;
    logic        w_fb;

    assign w_fb = lfsr_q[4] ^ data_in;

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        bit_cnt_d = bit_cnt_q;
        cap_d     = cap_q;
        done_d    = 1'b0;
        crc_ok_d  = crc_ok_q;
        addr_d    = addr_q;
        endp_d    = endp_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    lfsr_d    = c_LFSR_SEED;
                    bit_cnt_d = 4'd0;
                    cap_d     = 11'd0;
                end
            end

            ST_SHIFT: begin
                // A restart wins over any bit presented in the same cycle;
                // the partial frame is simply dropped.
                if (start) begin
                    lfsr_d    = c_LFSR_SEED;
                    bit_cnt_d = 4'd0;
                    cap_d     = 11'd0;
                end else if (data_valid) begin
                    lfsr_d = {lfsr_q[3:0], 1'b0} ^ (w_fb ? c_LFSR_POLY : 5'b00000);
                    if (bit_cnt_q < c_CAP_BITS) begin
                        cap_d[bit_cnt_q] = data_in;
                    end
                    // Counter wraps after the 16th bit; it is reloaded on the
                    // next start before it is used again.
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == c_LAST_BIT) begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                crc_ok_d = (lfsr_q == c_RESIDUAL);
                addr_d   = cap_q[6:0];
                endp_d   = cap_q[10:7];
                done_d   = 1'b1;
                if (start) begin
                    state_d   = ST_SHIFT;
                    lfsr_d    = c_LFSR_SEED;
                    bit_cnt_d = 4'd0;
                    cap_d     = 11'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= c_LFSR_SEED;
            bit_cnt_q <= 4'd0;
            cap_q     <= 11'd0;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            addr_q    <= 7'd0;
            endp_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            bit_cnt_q <= bit_cnt_d;
            cap_q     <= cap_d;
            done_q    <= done_d;
            crc_ok_q  <= crc_ok_d;
            addr_q    <= addr_d;
            endp_q    <= endp_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional saturating CRC error counter
    // ------------------------------------------------------------------------
`ifdef CRC5_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == ST_CHECK) && (lfsr_q != c_RESIDUAL) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    // busy is decoded from the state register only, so it falls on the
    // same edge that raises done.
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign crc_ok = crc_ok_q;
    assign addr   = addr_q;
    assign endp   = endp_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_token_crc5_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_token_crc5_checker
// Purpose  : Directed self-checking bench for usb_token_crc5_checker. Sends
//            good, corrupted, gapped, restarted and reset-interrupted tokens
//            and compares results against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_token_crc5_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       data_in;
    logic       data_valid;
    logic       busy;
    logic       done;
    logic       crc_ok;
    logic [6:0] addr;
    logic [3:0] endp;
    logic [7:0] err_cnt;

`ifdef CRC5_ERR_COUNT_EN
    localparam int ERR_STEP = 1;
`else
    localparam int ERR_STEP = 0;
`endif

    usb_token_crc5_checker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done),
        .crc_ok     (crc_ok),
        .addr       (addr),
        .endp       (endp),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_total  = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int s_cyc    = 0;
    int k_cyc    = 0;

    // Edge counter: after posedge n has been processed, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Wire order: addr[0..6], endp[0..3], then CRC field MSB first.
    function automatic logic [15:0] mk_stream(input logic [6:0] a, input logic [3:0] e,
                                              input logic [4:0] c);
        logic [15:0] s;
        for (int i = 0; i < 7; i++) s[i] = a[i];
        for (int i = 0; i < 4; i++) s[7 + i] = e[i];
        for (int i = 0; i < 5; i++) s[11 + i] = c[4 - i];
        return s;
    endfunction

    // Pulses start, then sends nbits bits with gap idle cycles before each.
    // Ends at the negedge after the edge that sampled the last bit.
    task automatic frame_bits(input logic [15:0] s, input int nbits, input int gap);
        @(negedge clk);
        start      = 1'b1;
        data_valid = 1'b0;
        s_cyc      = cyc + 1;
        for (int i = 0; i < nbits; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                start      = 1'b0;
                data_valid = 1'b0;
                if (i == 0 && g == 0) check("busy_after_start", busy, 1);
            end
            @(negedge clk);
            if (i == 0 && gap == 0) check("busy_after_start", busy, 1);
            start      = 1'b0;
            data_valid = 1'b1;
            data_in    = s[i];
            k_cyc      = cyc + 1;
        end
        @(negedge clk);
        start      = 1'b0;
        data_valid = 1'b0;
    endtask

    // Called right after a full frame_bits; checks the done edge and results.
    task automatic expect_token(input string tag, input int d0, input logic ok,
                                input logic [6:0] a, input logic [3:0] e,
                                input logic [7:0] ec);
        @(negedge clk);
        check({tag, ".done_cnt"},  done_cnt, d0 + 1);
        check({tag, ".done_edge"}, done_cyc, k_cyc + 1);
        check({tag, ".crc_ok"},    crc_ok, ok);
        check({tag, ".addr"},      addr, a);
        check({tag, ".endp"},      endp, e);
        check({tag, ".err_cnt"},   err_cnt, ec);
        check({tag, ".busy"},      busy, 0);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
    endtask

    logic [15:0] good1, bad1, good2;
    int d0;

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        data_in    = 1'b0;
        data_valid = 1'b0;
        good1 = mk_stream(7'h15, 4'hE, 5'h17);
        bad1  = good1 ^ 16'h0008;
        good2 = mk_stream(7'h3A, 4'hA, 5'h1C);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.busy",    busy, 0);
        check("rst.done",    done, 0);
        check("rst.crc_ok",  crc_ok, 0);
        check("rst.addr",    addr, 0);
        check("rst.endp",    endp, 0);
        check("rst.err_cnt", err_cnt, 0);
        rst = 1'b1;
        // Bits with no start are ignored in IDLE
        repeat (4) begin
            @(negedge clk);
            data_valid = 1'b1;
            data_in    = 1'b1;
        end
        @(negedge clk);
        data_valid = 1'b0;
        check("idle.busy", busy, 0);
        check("idle.done_cnt", done_cnt, 0);

        // Good token, back-to-back bits
        d0 = done_cnt;
        frame_bits(good1, 16, 0);
        expect_token("good", d0, 1'b1, 7'h15, 4'hE, 8'd0);
        check("good.latency", done_cyc - s_cyc, 17);

        // Corrupt token: bit 3 flipped
        d0 = done_cnt;
        frame_bits(bad1, 16, 0);
        expect_token("bad", d0, 1'b0, 7'h1D, 4'hE, 8'(ERR_STEP));

        // Gapped input: valid one cycle in three
        d0 = done_cnt;
        frame_bits(good1, 16, 2);
        expect_token("gap", d0, 1'b1, 7'h15, 4'hE, 8'(ERR_STEP));

        // Restart after 9 bits, then a different good token
        d0 = done_cnt;
        frame_bits(bad1, 9, 0);
        check("restart.partial_no_done", done_cnt, d0);
        frame_bits(good2, 16, 0);
        expect_token("restart", d0, 1'b1, 7'h3A, 4'hA, 8'(ERR_STEP));

        // Reset mid-frame after 12 bits, then idle traffic without start
        d0 = done_cnt;
        frame_bits(good1, 12, 0);
        #2;
        rst = 1'b0;
        #1;
        check("mrst.async_busy", busy, 0);
        check("mrst.async_addr", addr, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            data_valid = 1'b1;
            data_in    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        data_valid = 1'b0;
        check("mrst.done_cnt", done_cnt, d0);
        check("mrst.busy",     busy, 0);
        check("mrst.done",     done, 0);
        check("mrst.crc_ok",   crc_ok, 0);
        check("mrst.addr",     addr, 0);
        check("mrst.endp",     endp, 0);
        check("mrst.err_cnt",  err_cnt, 0);

`ifdef CRC5_ERR_COUNT_EN
        // Saturation: 300 corrupt tokens, then a good one
        d0 = done_cnt;
        for (int t = 0; t < 300; t++) begin
            frame_bits(bad1, 16, 0);
            @(negedge clk);
            if (t == 254) check("sat.at_255", err_cnt, 8'hFF);
        end
        check("sat.done_cnt", done_cnt, d0 + 300);
        check("sat.err_cnt",  err_cnt, 8'hFF);
        check("sat.crc_ok",   crc_ok, 0);
        d0 = done_cnt;
        frame_bits(good1, 16, 0);
        expect_token("sat_good", d0, 1'b1, 7'h15, 4'hE, 8'hFF);
`else
        // Without the counter, corrupt tokens leave err_cnt at zero
        d0 = done_cnt;
        for (int t = 0; t < 3; t++) begin
            frame_bits(bad1, 16, 0);
            @(negedge clk);
        end
        check("nocnt.done_cnt", done_cnt, d0 + 3);
        check("nocnt.err_cnt",  err_cnt, 0);
        check("nocnt.crc_ok",   crc_ok, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
